// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Frame layout: MAGIC, N[7:0], N[15:8], 4*N payload bytes, XOR checksum.
package imem_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_WR,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Assembles little-endian 32-bit words from a framed byte stream and writes them into imem.
// Holds the core in reset until a frame with a matching XOR checksum has been fully loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    loader_state_t     state_reg, state_next;
    logic [1:0]        lane_reg, lane_next;
    logic [31:0]       shift_reg, shift_next;
    logic [7:0]        csum_reg, csum_next;
    logic [15:0]       len_reg, len_next;
    logic [CNT_W-1:0]  word_idx_reg, word_idx_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              rx_ready_reg, we_reg, core_rst_n_reg, busy_reg, done_reg, error_reg;

    logic        accept;
    logic [15:0] len_cand;

    assign accept   = rx_valid & rx_ready_reg;
    assign len_cand = {rx_data, len_reg[7:0]};

    always_comb begin
        state_next    = state_reg;
        lane_next     = lane_reg;
        shift_next    = shift_reg;
        csum_next     = csum_reg;
        len_next      = len_reg;
        word_idx_next = word_idx_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        case (state_reg)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (accept && rx_data == MAGIC) state_next = LD_LEN0;
            end
            LD_LEN0: begin
                if (accept) begin
                    len_next[7:0] = rx_data;
                    state_next    = LD_LEN1;
                end
            end
            LD_LEN1: begin
                if (accept) begin
                    len_next = len_cand;
                    // N is checked against capacity in 17 bits so N == 2**ADDR_W is legal
                    if (len_cand == 16'd0 || {1'b0, len_cand} > MAX_WORDS) begin
                        state_next = LD_ERR;
                    end else begin
                        state_next    = LD_DATA;
                        word_idx_next = '0;
                        lane_next     = 2'd0;
                        csum_next     = 8'd0;
                    end
                end
            end
            LD_DATA: begin
                if (accept) begin
                    shift_next[{lane_reg, 3'b000} +: 8] = rx_data;
                    csum_next = csum_reg ^ rx_data;
                    if (lane_reg == 2'd3) begin
                        wdata_next = shift_next;
                        addr_next  = word_idx_reg[ADDR_W-1:0];
                        state_next = LD_WR;
                    end else begin
                        lane_next = lane_reg + 2'd1;
                    end
                end
            end
            LD_WR: begin
                word_idx_next = word_idx_reg + CNT_W'(1);
                lane_next     = 2'd0;
                if (17'(word_idx_reg) + 17'd1 == {1'b0, len_reg}) state_next = LD_CSUM;
                else                                              state_next = LD_DATA;
            end
            LD_CSUM: begin
                if (accept) state_next = (rx_data == csum_reg) ? LD_DONE : LD_ERR;
            end
            default: state_next = LD_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= LD_IDLE;
            lane_reg       <= 2'd0;
            shift_reg      <= '0;
            csum_reg       <= '0;
            len_reg        <= '0;
            word_idx_reg   <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rx_ready_reg   <= 1'b1;
            we_reg         <= 1'b0;
            core_rst_n_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lane_reg       <= lane_next;
            shift_reg      <= shift_next;
            csum_reg       <= csum_next;
            len_reg        <= len_next;
            word_idx_reg   <= word_idx_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rx_ready_reg   <= (state_next != LD_WR);
            we_reg         <= (state_next == LD_WR);
            core_rst_n_reg <= (state_next == LD_DONE);
            busy_reg       <= (state_next inside {LD_LEN0, LD_LEN1, LD_DATA, LD_WR, LD_CSUM});
            done_reg       <= (state_next == LD_DONE);
            error_reg      <= (state_next == LD_ERR);
        end
    end

    assign rx_ready   = rx_ready_reg;
    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign core_rst_n = core_rst_n_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed byte streams with hand-derived expected writes and status.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready, imem_we, core_rst_n, busy, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int bad_ready = 0;
    int wr_snap;
    logic [31:0] frame_words [0:CAP-1];

    imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Count writes and any stall cycle that is not a write cycle.
    always @(negedge clk) begin
        if (rst_n && imem_we) wr_count++;
        if (rst_n && !rx_ready && !imem_we) bad_ready++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] w);
        check({tag, "_we"},    32'(imem_we),   32'd1);
        check({tag, "_addr"},  32'(imem_addr), 32'(idx % CAP));
        check({tag, "_wdata"}, imem_wdata,     w);
        check({tag, "_stall"}, 32'(rx_ready),  32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic b, input logic c);
        check({tag, "_done"},  32'(done),       32'(d));
        check({tag, "_error"}, 32'(error),      32'(e));
        check({tag, "_busy"},  32'(busy),       32'(b));
        check({tag, "_core"},  32'(core_rst_n), 32'(c));
    endtask

    // Sends a frame of n words from frame_words with random byte gaps up to max_gap.
    task automatic send_frame(input string tag, input int n, input logic bad_csum, input int max_gap);
        logic [7:0]  csum;
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        csum = 8'h00;
        send_byte(8'hA5);
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int b = 0; b < 4; b++) begin
                gap($urandom_range(0, max_gap));
                send_byte(w[8*b +: 8]);
                csum = csum ^ w[8*b +: 8];
            end
            check_write(tag, i, w);
        end
        send_byte(bad_csum ? (csum ^ 8'h01) : csum);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rx_ready),   32'd1);
        check("rst_we",    32'(imem_we),    32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_wdata", imem_wdata,      32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Junk before MAGIC is discarded
        send_byte(8'h00);
        send_byte(8'hFF);
        check_status("junk", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-word frame, hand checksum 13^05^A0^00 = B6
        wr_snap = wr_count;
        send_byte(8'hA5);
        check("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        check_write("t1", 0, 32'h00A00513);
        send_byte(8'hB6);
        check_status("t1_end", 1'b1, 1'b0, 1'b0, 1'b1);
        check("t1_nwr", 32'(wr_count - wr_snap), 32'd1);

        // Non-MAGIC bytes in DONE are ignored
        send_byte(8'h00);
        check_status("done_junk", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reload: MAGIC drops core reset on the next cycle, second frame loads addi x1,x0,1
        send_byte(8'hA5);
        check_status("reload_start", 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check_write("reload", 0, 32'h00100093);
        send_byte(8'h83);
        check_status("reload_end", 1'b1, 1'b0, 1'b0, 1'b1);

        // Bad checksum: word still written, frame rejected
        wr_snap = wr_count;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        check_write("t3", 0, 32'h00A00513);
        send_byte(8'hB7);
        check_status("t3_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_nwr", 32'(wr_count - wr_snap), 32'd1);

        // N == 0 rejected with no writes
        wr_snap = wr_count;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check_status("n0", 1'b0, 1'b1, 1'b0, 1'b0);
        check("n0_nwr", 32'(wr_count - wr_snap), 32'd0);

        // N == 2**ADDR_W + 1 (0x0401) rejected
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        check_status("nbig", 1'b0, 1'b1, 1'b0, 1'b0);
        check("nbig_nwr", 32'(wr_count - wr_snap), 32'd0);

        // Full-capacity frame: last address is 2**ADDR_W-1
        for (int i = 0; i < CAP; i++) frame_words[i] = 32'(i) * 32'h01000193 ^ 32'h5A5A0000;
        wr_snap = wr_count;
        send_frame("full", CAP, 1'b0, 0);
        check_status("full_end", 1'b1, 1'b0, 1'b0, 1'b1);
        check("full_nwr", 32'(wr_count - wr_snap), 32'(CAP));
        check("full_last_addr", 32'(imem_addr), 32'(CAP - 1));

        // Three words with random valid gaps; stalls only in write cycles
        frame_words[0] = 32'hDEADBEEF;
        frame_words[1] = 32'h12345678;
        frame_words[2] = 32'h0000FFFF;
        wr_snap = wr_count;
        bad_ready = 0;
        send_frame("t2", 3, 1'b0, 3);
        check_status("t2_end", 1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_nwr", 32'(wr_count - wr_snap), 32'd3);
        check("t2_stall_only_wr", 32'(bad_ready), 32'd0);

        // Async reset in the middle of a word (lane 2)
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(rx_ready),  32'd1);
        check("arst_we",    32'(imem_we),   32'd0);
        check("arst_addr",  32'(imem_addr), 32'd0);
        check("arst_wdata", imem_wdata,     32'd0);
        check_status("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_words[0] = 32'h00100093;
        send_frame("after_rst", 1, 1'b0, 1);
        check_status("after_rst_end", 1'b1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
